// File: rtl/datapath_pipe.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pipe
// Description : N-bit add/sub datapath with a configurable-depth elastic
//               result pipeline (valid/ready), signed overflow and zero flags.
//               opcode[2] forces B to zero, opcode[1] inverts B, and
//               opcode[0] is the carry-in.
//
// Parameters  : N      - operand/result width (N >= 2)
//               STAGES - number of result pipeline registers (0..4);
//                        0 gives a combinational pass-through
//
// Macro       : DATAPATH_SAT_EN - when defined, an overflowing result is
//               clamped to the signed bound before it enters stage 1
//
// Ports       : clk        in   clock, rising edge
//               rst_n      in   asynchronous active-low reset
//               in_valid   in   operand beat valid
//               in_ready   out  operand beat can be accepted this cycle
//               A, B       in   signed operands, N bits
//               opcode     in   3-bit operation select
//               out_valid  out  result beat valid
//               out_ready  in   downstream accepts result this cycle
//               Y          out  result, N bits
//               co         out  carry-out of the N-bit add
//               ov         out  signed overflow
//               zero       out  Y == 0
//               occupancy  out  number of valid pipeline stages held
//
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_pipe #(
    parameter int N      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic         co,
    output logic         ov,
    output logic         zero,
    output logic [2:0]   occupancy
);

    // Stage payload is {Y, co, ov, zero}
    localparam int W = N + 3;

    // ------------------------------------------------------------------
    // Operand path
    // ------------------------------------------------------------------
    logic [N-1:0] w_b_mux;
    logic [N-1:0] w_b_eff;
    logic [N:0]   w_sum;
    logic         w_co;
    logic         w_ov;
    logic [N-1:0] w_res;
    logic         w_zero;
    logic [W-1:0] w_payload;

    assign w_b_mux = opcode[2] ? '0 : B;
    assign w_b_eff = opcode[1] ? ~w_b_mux : w_b_mux;
    assign w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{N{1'b0}}, opcode[0]};
    assign w_co    = w_sum[N];
    // Equivalent to (carry into bit N-1) XOR carry-out: overflow happens
    // exactly when both addends share a sign that the sum does not.
    assign w_ov    = (A[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != A[N-1]);

`ifdef DATAPATH_SAT_EN
    localparam logic [N-1:0] c_SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_SAT_MIN = {1'b1, {(N-1){1'b0}}};
    // On overflow the true result has the sign of A, so clamp toward it.
    assign w_res = w_ov ? (A[N-1] ? c_SAT_MIN : c_SAT_MAX) : w_sum[N-1:0];
`else
    assign w_res = w_sum[N-1:0];
`endif

    assign w_zero    = (w_res == '0);
    assign w_payload = {w_res, w_co, w_ov, w_zero};

    // ------------------------------------------------------------------
    // Result pipeline
    // ------------------------------------------------------------------
    generate
        if (STAGES == 0) begin : g_comb
            assign out_valid              = in_valid;
            assign in_ready               = out_ready;
            assign {Y, co, ov, zero}      = w_payload;
            assign occupancy              = 3'd0;
        end else begin : g_pipe
            logic [STAGES-1:0] valid_q;
            logic [STAGES-1:0] valid_d;
            logic [STAGES-1:0] w_adv;   // stage k hands its beat onward
            logic [STAGES-1:0] w_load;  // stage k captures a beat
            logic [STAGES:0]   w_free;  // slot k can take a beat this cycle
            logic [W-1:0]      pay_q [STAGES];
            logic [2:0]        occ_q;
            logic [2:0]        occ_d;

            // The ready chain walks back from out_ready so that a full
            // pipeline can accept and emit in the same cycle.
            always_comb begin
                w_free         = '0;
                w_adv          = '0;
                w_load         = '0;
                valid_d        = '0;
                occ_d          = '0;
                w_free[STAGES] = out_ready;
                for (int k = STAGES - 1; k >= 0; k--) begin
                    w_adv[k]  = valid_q[k] && w_free[k+1];
                    w_free[k] = !valid_q[k] || w_adv[k];
                end
                w_load[0] = in_valid && w_free[0];
                for (int k = 1; k < STAGES; k++) begin
                    w_load[k] = w_adv[k-1];
                end
                for (int k = 0; k < STAGES; k++) begin
                    valid_d[k] = w_load[k] || (valid_q[k] && !w_adv[k]);
                    occ_d      = occ_d + 3'(valid_d[k]);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    occ_q   <= '0;
                    for (int k = 0; k < STAGES; k++) begin
                        pay_q[k] <= '0;
                    end
                end else begin
                    valid_q <= valid_d;
                    occ_q   <= occ_d;
                    // Payload moves only with a beat, so idle inputs never
                    // disturb held data.
                    if (w_load[0]) begin
                        pay_q[0] <= w_payload;
                    end
                    for (int k = 1; k < STAGES; k++) begin
                        if (w_load[k]) begin
                            pay_q[k] <= pay_q[k-1];
                        end
                    end
                end
            end

            assign in_ready          = w_free[0];
            assign out_valid         = valid_q[STAGES-1];
            assign {Y, co, ov, zero} = pay_q[STAGES-1];
            assign occupancy         = occ_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_datapath_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_pipe
// Description : Directed self-checking bench for datapath_pipe (N=16,
//               STAGES=2). Honours DATAPATH_SAT_EN for saturated results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_pipe;

    localparam int N      = 16;
    localparam int STAGES = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic [2:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  Y;
    logic          co;
    logic          ov;
    logic          zero;
    logic [2:0]    occupancy;

    int n_cmp = 0;
    int n_err = 0;

    datapath_pipe #(
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .co        (co),
        .ov        (ov),
        .zero      (zero),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] op);
        in_valid = v;
        A        = a;
        B        = b;
        opcode   = op;
    endtask

    // One beat into an empty pipeline, out_ready=1; checks 2-cycle latency.
    task automatic send_check(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [2:0] op, input logic [N-1:0] ey,
                              input logic eco, input logic eov, input logic ez);
        drive(1'b1, a, b, op);
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 16'hDEAD, 16'hBEEF, 3'b000);
        chk({tag, ".lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".Y"},     32'(Y),         32'(ey));
        chk({tag, ".co"},    32'(co),        32'(eco));
        chk({tag, ".ov"},    32'(ov),        32'(eov));
        chk({tag, ".zero"},  32'(zero),      32'(ez));
        tick();
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 3'b000);
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.Y",         32'(Y),         32'd0);
        chk("rst.flags",     32'({co, ov, zero}), 32'd0);
        chk("rst.occ",       32'(occupancy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- arithmetic ----------------
`ifdef DATAPATH_SAT_EN
        send_check("t1_ovf",   16'h7FFF, 16'h0001, 3'b000, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        send_check("neg_ovf",  16'h8000, 16'hFFFF, 3'b000, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        send_check("t1_ovf",   16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 1'b1, 1'b0);
        send_check("neg_ovf",  16'h8000, 16'hFFFF, 3'b000, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
        send_check("t2_sub",   16'h0005, 16'h0005, 3'b011, 16'h0000, 1'b1, 1'b0, 1'b1);
        send_check("t2_dec",   16'h0000, 16'h1234, 3'b110, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        send_check("t3_passA", 16'h1234, 16'hFFFF, 3'b100, 16'h1234, 1'b0, 1'b0, 1'b0);
        send_check("t3_inc",   16'h1234, 16'hFFFF, 3'b101, 16'h1235, 1'b0, 1'b0, 1'b0);
        send_check("subm1",    16'h0003, 16'h0001, 3'b010, 16'h0001, 1'b1, 1'b0, 1'b0);
        send_check("op111",    16'h0000, 16'h5555, 3'b111, 16'h0000, 1'b1, 1'b0, 1'b1);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        drive(1'b1, 16'd1, 16'd0, 3'b000);
        #1;
        chk("bp.rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 16'd2, 16'd0, 3'b000);
        #1;
        chk("bp.rdy2", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 16'd3, 16'd0, 3'b000);
        #1;
        chk("bp.full_rdy", 32'(in_ready),  32'd0);
        chk("bp.full_occ", 32'(occupancy), 32'd2);
        chk("bp.head",     32'(Y),         32'd1);
        tick();
        chk("bp.hold_occ", 32'(occupancy), 32'd2);
        chk("bp.hold_Y",   32'(Y),         32'd1);
        chk("bp.hold_vld", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("bp.out2", 32'(Y), 32'd2);
        drive(1'b1, 16'd4, 16'd0, 3'b000);
        tick();
        chk("bp.out3", 32'(Y), 32'd3);
        drive(1'b0, '0, '0, 3'b000);
        tick();
        chk("bp.out4",   32'(Y),         32'd4);
        chk("bp.vld4",   32'(out_valid), 32'd1);
        tick();
        chk("bp.empty",  32'(out_valid), 32'd0);
        chk("bp.occ0",   32'(occupancy), 32'd0);

        // ---------------- accept and consume when full ----------------
        out_ready = 1'b0;
        drive(1'b1, 16'd10, 16'd0, 3'b000);
        tick();
        drive(1'b1, 16'd11, 16'd0, 3'b000);
        tick();
        drive(1'b1, 16'd12, 16'd0, 3'b000);
        out_ready = 1'b1;
        #1;
        chk("ac.occ0",  32'(occupancy), 32'd2);
        chk("ac.head",  32'(Y),         32'd10);
        chk("ac.rdy",   32'(in_ready),  32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ac.occ", 32'(occupancy), 32'd2);
            chk("ac.Y",   32'(Y),         32'(11 + i));
            drive(1'b1, 16'(13 + i), 16'd0, 3'b000);
        end
        drive(1'b0, '0, '0, 3'b000);
        tick();
        chk("ac.tail_Y",   32'(Y),         32'd14);
        chk("ac.tail_occ", 32'(occupancy), 32'd1);
        tick();
        chk("ac.empty", 32'(out_valid), 32'd0);
        chk("ac.occ_e", 32'(occupancy), 32'd0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        drive(1'b1, 16'd20, 16'd0, 3'b000);
        tick();
        drive(1'b1, 16'd21, 16'd0, 3'b000);
        tick();
        drive(1'b0, '0, '0, 3'b000);
        chk("mr.pre_occ", 32'(occupancy), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr.out_valid", 32'(out_valid), 32'd0);
        chk("mr.Y",         32'(Y),         32'd0);
        chk("mr.occ",       32'(occupancy), 32'd0);
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mr.stale1", 32'(out_valid), 32'd0);
        tick();
        chk("mr.stale2", 32'(out_valid), 32'd0);
        send_check("mr.next", 16'h0055, 16'h0000, 3'b000, 16'h0055, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
Parametrised successor to the team's single-cycle add/sub datapath. It keeps the same 3-bit opcode encoding: B-zero select, B-invert and carry-in. It adds a configurable-depth elastic output pipeline with valid/ready handshake, an asynchronous reset, and signed overflow and zero flags. It sits between the operand sequencer and the result writeback in the arithmetic path.

Parameters:
N, 16, operand/result width in bits (N >= 2)
STAGES, 2, number of result pipeline registers (0..4). 0 = fully combinational pass-through.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat this cycle
A  input  N  signed operand A
B  input  N  signed operand B
opcode  input  3  [2]=force B to 0, [1]=invert B, [0]=carry-in
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result this cycle
Y  output  N  result
co  output  1  carry-out of the N-bit add
ov  output  1  signed two's-complement overflow
zero  output  1  Y == 0
occupancy  output  3  number of valid pipeline stages currently held (0..STAGES)

Behaviour:
- Reset is asynchronous on rst_n low. While rst_n is low, all stage valid bits = 0, all data/flag registers = 0, out_valid = 0, Y/co/ov/zero = 0 and occupancy = 0. In-flight beats are discarded.
- Operand path (combinational from the input port):
  - b_mux = opcode[2] ? 0 : B
  - b_eff = opcode[1] ? ~b_mux : b_mux
  - {co, sum} = A + b_eff + opcode[0], computed at N+1 bits
- ov = carry into bit N-1 XOR co. zero = (result == 0), evaluated on the final result, i.e. after saturation when that is enabled.
- Opcode results:
  - 000 = A+B
  - 001 = A+B+1
  - 010 = A-B-1
  - 011 = A-B
  - 100 = A
  - 101 = A+1
  - 110 = A-1
  - 111 = A
- Pipeline: STAGES registers, each holding {valid, Y, co, ov, zero}.
  - Stage 1 captures the computed result when in_valid && in_ready.
  - Stage k advances to stage k+1 when stage k+1 is empty or stage k+1 itself advances.
  - The last stage is consumed when out_valid && out_ready.
  - in_ready = !valid[1] || stage 1 advances this cycle. The ready chain is combinational back from out_ready.
  - With all stages empty, latency is exactly STAGES cycles from accept to out_valid.
  - Throughput is one beat per cycle while out_ready = 1.
- Output holding: while out_valid = 1 and out_ready = 0, Y/co/ov/zero hold stable. No beat is dropped, duplicated or reordered.
- Full condition: all STAGES valid with out_ready = 0 gives in_ready = 0. Beats presented on in_valid are not accepted and are not consumed.
- Simultaneous accept and consume when full: allowed. Occupancy is unchanged and data shifts by one.
- occupancy = popcount of the stage valid bits, registered with the stages.
- STAGES = 0: out_valid = in_valid, in_ready = out_ready, outputs combinational from the inputs, occupancy = 0. rst_n has no effect on the data path in this case.
- Input data values are don't-care when in_valid = 0, and they never enter a stage.

Optional Feature:
Macro DATAPATH_SAT_EN.
- Defined: when ov = 1, Y is clamped to the signed bound before stage 1. The result is 2^(N-1)-1 if A[N-1] = 0, else -2^(N-1). ov still reports 1 and co is unchanged; zero is computed on the clamped value.
- Undefined: Y is the wrapped N-bit sum.

Test Plan:
All scenarios use N=16, STAGES=2 and out_ready=1 unless stated otherwise.
1. A=0x7FFF, B=0x0001, op=000 -> 2 cycles later Y=0x8000, co=0, ov=1, zero=0. With DATAPATH_SAT_EN defined: Y=0x7FFF, ov=1.
2. A=0x0005, B=0x0005, op=011 -> Y=0x0000, co=1, ov=0, zero=1. Then A=0x0000, op=110 -> Y=0xFFFF, co=0, ov=0.
3. A=0x1234, B=0xFFFF, op=100 -> Y=0x1234, co=0. Then op=101 -> Y=0x1235.
4. Backpressure: out_ready=0, present 4 back-to-back beats with A=1,2,3,4, B=0, op=000.
   - Beats 1-2 are accepted; in_ready drops to 0 and occupancy=2.
   - Raise out_ready: outputs are 1,2,3,4 in order, one per cycle, with no loss.
5. Accept and consume when full: hold the pipeline full, then set out_ready=1 and in_valid=1 together -> occupancy stays 2 for 3 consecutive cycles and output order is preserved.
6. Reset mid-operation: assert rst_n=0 for 1 cycle (asynchronously, mid-clock) with 2 beats in flight -> out_valid=0, Y=0 and occupancy=0 immediately. After release, no stale beat emerges and the next beat appears after 2 cycles.
